sub_seq_ctrl: RTL and testbench
===============================

SUB_SEQ_CTRL -- requirements
Module: sub_seq_ctrl

Interface
REQ-001 SHALL provide parameter WORD_W, default 16, width of the shared subtract slice in bits.
REQ-002 SHALL provide parameter NWORDS, default 4, number of slice words per operand (operand width = WORD_W*NWORDS).
REQ-003 SHALL provide port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL provide port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL provide ports in_valid input 1 and in_ready output 1, the operand handshake.
REQ-006 SHALL provide ports a and b, each input WORD_W*NWORDS, minuend and subtrahend.
REQ-007 SHALL provide port bin  input  1  initial borrow, sampled with a and b.
REQ-008 SHALL provide ports out_valid output 1 and out_ready input 1, the result handshake.
REQ-009 SHALL provide port diff  output  WORD_W*NWORDS  registered difference a-b-bin.
REQ-010 SHALL provide port bout  output  1  final borrow out of the most significant word.

Function
REQ-011 SHALL implement FSM states IDLE, RUN, DONE.
REQ-012 SHALL drive in_ready=1 only in IDLE; out_valid=1 only in DONE.
REQ-013 SHALL, on an edge with in_valid&&in_ready, capture a, b, bin into internal registers, clear the word index to 0, and enter RUN.
REQ-014 SHALL, in RUN, apply one WORD_W-bit slice per cycle to word[idx] of the captured operands, with borrow-in = bin for idx 0 and the registered borrow-out of word idx-1 otherwise.
REQ-015 SHALL, on each RUN edge, write slice difference into diff word[idx], register the slice borrow-out, and increment idx.
REQ-016 SHALL leave RUN for DONE on the edge that processes idx=NWORDS-1; bout = that slice's borrow-out.
REQ-017 SHALL present out_valid exactly NWORDS cycles after the accepting edge (latency NWORDS).
REQ-018 SHALL hold diff and bout stable in DONE while out_ready=0.
REQ-019 SHALL return to IDLE on the edge with out_valid&&out_ready; no new operand accepted on that same edge.
REQ-020 SHALL ignore in_valid and changes on a, b, bin while in RUN or DONE.
REQ-021 SHALL compute modulo 2^(WORD_W*NWORDS); bout=1 exactly when a < b+bin as unsigned.
REQ-022 SHALL keep diff and bout unchanged in IDLE until the next RUN overwrites them.

Reset
REQ-023 SHALL, while rst_n=0, force state IDLE, idx 0, borrow register 0, diff 0, bout 0, out_valid 0, in_ready 1.
REQ-024 SHALL abort any RUN or DONE operation on reset assertion; the partial result is discarded.
REQ-025 SHALL accept a new operand on the first edge after rst_n deasserts if in_valid=1.

Configuration
REQ-026 SHALL honour macro SUB_SEQ_SAT_EN: when defined, on entering DONE with final borrow 1, diff SHALL be forced to 0 (unsigned floor-at-zero), bout still 1.
REQ-027 SHALL, without SUB_SEQ_SAT_EN, output the wrapped two's-complement difference unchanged.

Structure
REQ-028 SHALL place the FSM state enum and default WORD_W/NWORDS constants in shared package sub_pkg.
REQ-029 SHALL instantiate exactly one sub-module, sub_slice, a purely combinational WORD_W-bit ripple full-subtract slice (a, b, bin -> diff, bout).
REQ-030 SHALL contain no second slice instance; datapath sharing across words is by time multiplexing only.

Verification
REQ-031 SHALL cover a=0x0001_0000_0000_0000, b=0x1, bin=0 -> diff=0x0000_FFFF_FFFF_FFFF, bout=0, out_valid 4 cycles after accept.
REQ-032 SHALL cover a=0, b=1, bin=0 -> diff=0xFFFF_FFFF_FFFF_FFFF, bout=1; with SUB_SEQ_SAT_EN diff=0, bout=1.
REQ-033 SHALL cover a=0x1234_5678_9ABC_DEF0, b=0x1234_5678_9ABC_DEEF, bin=1 -> diff=0, bout=0.
REQ-034 SHALL cover out_ready held 0 for 10 cycles in DONE -> diff/bout stable, in_ready=0, in_valid pulses ignored.
REQ-035 SHALL cover rst_n pulsed low at RUN idx=2 -> state IDLE, diff=0, out_valid=0 immediately; next operand completes correctly.
REQ-036 SHALL cover back-to-back ops with out_ready=1 and in_valid=1 held -> one result per NWORDS+2 cycles, each matching a reference a-b-bin.

Source files
------------

// File: rtl/sub_pkg.sv
// Shared types and default sizing for the sequential multi-word subtractor.
package sub_pkg;
  localparam int WORD_W_DEF = 16;
  localparam int NWORDS_DEF = 4;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
endpackage

// File: rtl/sub_slice.sv
// Combinational WORD_W-bit full-subtract slice: {bout,diff} = a - b - bin.
module sub_slice #(
  parameter int WORD_W = 16
) (
  input  logic [WORD_W-1:0] a,
  input  logic [WORD_W-1:0] b,
  input  logic              bin,
  output logic [WORD_W-1:0] diff,
  output logic              bout
);
  logic [WORD_W:0] r;

  // The extra top bit goes negative exactly when a borrow leaves the slice.
  assign r    = {1'b0, a} - {1'b0, b} - {{WORD_W{1'b0}}, bin};
  assign diff = r[WORD_W-1:0];
  assign bout = r[WORD_W];
endmodule

// File: rtl/sub_seq_ctrl.sv
// Sequential a-b-bin over NWORDS words through a single shared slice, one word per cycle.
// Optional SUB_SEQ_SAT_EN floors an underflowing result at zero (bout still reports it).
module sub_seq_ctrl
  import sub_pkg::*;
#(
  parameter int WORD_W = WORD_W_DEF,
  parameter int NWORDS = NWORDS_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WORD_W*NWORDS-1:0] a,
  input  logic [WORD_W*NWORDS-1:0] b,
  input  logic                     bin,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WORD_W*NWORDS-1:0] diff,
  output logic                     bout
);
  localparam int W  = WORD_W * NWORDS;
  localparam int IW = (NWORDS > 1) ? $clog2(NWORDS) : 1;

  state_t          st, st_nx;
  logic [IW-1:0]   idx;
  logic            brw;
  logic [W-1:0]    a_r, b_r, diff_q;
  logic            bin_r, bout_q;

  logic [WORD_W-1:0] s_a, s_b, s_d;
  logic              s_bin, s_bo;
  logic              last;

  assign last  = (idx == IW'(NWORDS - 1));
  assign s_a   = a_r[int'(idx)*WORD_W +: WORD_W];
  assign s_b   = b_r[int'(idx)*WORD_W +: WORD_W];
  assign s_bin = (idx == '0) ? bin_r : brw;

  sub_slice #(.WORD_W(WORD_W)) u_slice (
    .a    (s_a),
    .b    (s_b),
    .bin  (s_bin),
    .diff (s_d),
    .bout (s_bo)
  );

  assign in_ready  = (st == IDLE);
  assign out_valid = (st == DONE);
  assign diff      = diff_q;
  assign bout      = bout_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) st <= IDLE;
    else        st <= st_nx;
  end

  always_comb begin
    st_nx = st;
    case (st)
      IDLE:    if (in_valid)  st_nx = RUN;
      RUN:     if (last)      st_nx = DONE;
      DONE:    if (out_ready) st_nx = IDLE;
      default:                st_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx    <= '0;
      brw    <= 1'b0;
      a_r    <= '0;
      b_r    <= '0;
      bin_r  <= 1'b0;
      diff_q <= '0;
      bout_q <= 1'b0;
    end else begin
      case (st)
        IDLE: if (in_valid) begin
          a_r   <= a;
          b_r   <= b;
          bin_r <= bin;
          idx   <= '0;
        end
        RUN: begin
          diff_q[int'(idx)*WORD_W +: WORD_W] <= s_d;
          brw <= s_bo;
          if (last) begin
            idx    <= '0;
            bout_q <= s_bo;
`ifdef SUB_SEQ_SAT_EN
            // Later assignment overrides the top-word write above.
            if (s_bo) diff_q <= '0;
`endif
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_sub_seq_ctrl.sv
// Scoreboard bench for sub_seq_ctrl (default WORD_W=16, NWORDS=4).
module tb_sub_seq_ctrl;
  localparam int W = 64;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0, in_ready;
  logic [W-1:0] a = '0, b = '0, diff;
  logic         bin = 1'b0, bout;
  logic         out_valid, out_ready = 1'b0;

  int tests = 0;
  int fails = 0;
  logic [W:0] sbq[$];

  always #5 clk = ~clk;

  sub_seq_ctrl dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .bin(bin), .out_valid(out_valid), .out_ready(out_ready),
    .diff(diff), .bout(bout)
  );

  function automatic logic [W:0] model(input logic [W-1:0] x, input logic [W-1:0] y, input logic bi);
    logic [W:0] r;
    r = {1'b0, x} - {1'b0, y} - {{W{1'b0}}, bi};
`ifdef SUB_SEQ_SAT_EN
    if (r[W]) r[W-1:0] = '0;
`endif
    return r;
  endfunction

  // Drives one operand at a negedge in IDLE; returns at the negedge after acceptance.
  task automatic send(input logic [W-1:0] x, input logic [W-1:0] y, input logic bi);
    a = x; b = y; bin = bi; in_valid = 1'b1;
    sbq.push_back(model(x, y, bi));
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    a = {$urandom, $urandom}; b = {$urandom, $urandom}; bin = ~bin;
  endtask

  task automatic wait_out(output int lat, output bit to);
    lat = 0; to = 1'b1;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); @(negedge clk);
      if (out_valid) begin lat = n; to = 1'b0; break; end
    end
  endtask

  task automatic ack();
    out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    tests++; if (in_ready !== 1'b1)  begin fails++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    tests++; if (diff !== '0)        begin fails++; $display("FAIL reset_diff got %h exp 0", diff); end
    tests++; if (bout !== 1'b0)      begin fails++; $display("FAIL reset_bout got %b exp 0", bout); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single(input string nm, input logic [W-1:0] x, input logic [W-1:0] y, input logic bi);
    int lat; bit to; logic [W:0] e;
    send(x, y, bi);
    wait_out(lat, to);
    e = sbq.pop_front();
    tests++; if (to || lat != 4) begin fails++; $display("FAIL %s_latency got %0d exp 4 (timeout=%0b)", nm, lat, to); end
    tests++; if (diff !== e[W-1:0]) begin fails++; $display("FAIL %s_diff got %h exp %h", nm, diff, e[W-1:0]); end
    tests++; if (bout !== e[W])     begin fails++; $display("FAIL %s_bout got %b exp %b", nm, bout, e[W]); end
    ack();
    tests++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      fails++; $display("FAIL %s_idle got rdy=%b vld=%b exp rdy=1 vld=0", nm, in_ready, out_valid);
    end
  endtask

  task automatic test_stall();
    int lat; bit to; logic [W:0] e;
    send(64'h8000_0000_0000_0001, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1);
    wait_out(lat, to);
    e = sbq.pop_front();
    tests++; if (to) begin fails++; $display("FAIL stall_timeout got no out_valid exp out_valid"); end
    for (int i = 0; i < 10; i++) begin
      in_valid = i[0]; a = {$urandom, $urandom}; b = {$urandom, $urandom}; bin = i[1];
      @(posedge clk); @(negedge clk);
      tests++; if (diff !== e[W-1:0] || bout !== e[W]) begin
        fails++; $display("FAIL stall_hold cyc %0d got %h/%b exp %h/%b", i, diff, bout, e[W-1:0], e[W]);
      end
      tests++; if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
        fails++; $display("FAIL stall_hs cyc %0d got rdy=%b vld=%b exp rdy=0 vld=1", i, in_ready, out_valid);
      end
    end
    // in_valid held through the completing handshake must not be accepted.
    in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b0;
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL stall_no_accept got rdy=%b exp 1", in_ready); end
    @(negedge clk);
  endtask

  task automatic test_reset_abort();
    int lat; bit to; logic [W:0] e;
    logic [W-1:0] x, y;
    send(64'hFFFF_0000_FFFF_0000, 64'h0001_0001_0001_0001, 1'b0);
    void'(sbq.pop_back());
    @(posedge clk); @(posedge clk); @(negedge clk);
    rst_n = 1'b0;
    #1;
    tests++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      fails++; $display("FAIL abort_hs got vld=%b rdy=%b exp vld=0 rdy=1", out_valid, in_ready);
    end
    tests++; if (diff !== '0 || bout !== 1'b0) begin
      fails++; $display("FAIL abort_result got %h/%b exp 0/0", diff, bout);
    end
    @(negedge clk);
    x = {$urandom, $urandom}; y = {$urandom, $urandom};
    a = x; b = y; bin = 1'b1; in_valid = 1'b1;
    sbq.push_back(model(x, y, 1'b1));
    rst_n = 1'b1;
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL abort_first_accept got rdy=%b exp 0", in_ready); end
    wait_out(lat, to);
    e = sbq.pop_front();
    tests++; if (to || lat != 4) begin fails++; $display("FAIL abort_latency got %0d exp 4", lat); end
    tests++; if (diff !== e[W-1:0] || bout !== e[W]) begin
      fails++; $display("FAIL abort_next got %h/%b exp %h/%b", diff, bout, e[W-1:0], e[W]);
    end
    ack();
  endtask

  task automatic test_back_to_back();
    int got = 0, pushed = 0, last = -1;
    logic [W:0] e;
    logic [W-1:0] x, y;
    logic bi;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 200 && got < 5; cyc++) begin
      if (in_ready) begin
        if (pushed < 5) begin
          x = {$urandom, $urandom}; y = {$urandom, $urandom}; bi = 1'($urandom);
          a = x; b = y; bin = bi; in_valid = 1'b1;
          sbq.push_back(model(x, y, bi));
          pushed++;
        end else in_valid = 1'b0;
      end
      if (out_valid) begin
        e = sbq.pop_front();
        tests++; if (diff !== e[W-1:0] || bout !== e[W]) begin
          fails++; $display("FAIL b2b_result %0d got %h/%b exp %h/%b", got, diff, bout, e[W-1:0], e[W]);
        end
        if (last >= 0) begin
          tests++; if (cyc - last != 6) begin fails++; $display("FAIL b2b_spacing got %0d exp 6", cyc - last); end
        end
        last = cyc; got++;
      end
      @(negedge clk);
      if (!in_ready) in_valid = 1'b0;
    end
    in_valid = 1'b0; out_ready = 1'b0;
    tests++; if (got != 5 || sbq.size() != 0) begin
      fails++; $display("FAIL b2b_count got %0d (left %0d) exp 5 (left 0)", got, sbq.size());
    end
  endtask

  initial begin
    test_reset();
    test_single("carry_chain", 64'h0001_0000_0000_0000, 64'h1, 1'b0);
    test_single("underflow",   64'h0, 64'h1, 1'b0);
    test_single("bin_exact",   64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEEF, 1'b1);
    test_single("equal_bin",   64'h5555_5555_5555_5555, 64'h5555_5555_5555_5555, 1'b1);
    test_single("max_minus",   64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1);
    for (int i = 0; i < 4; i++)
      test_single("random", {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom));
    test_stall();
    test_reset_abort();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
